// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-file slave.
package spi_reg_pkg;

    // clk must run at least this many times faster than sck.
    localparam int SPI_MIN_OVERSAMPLE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronisers for the SPI pins plus sck leading/trailing and ss edge detection.
module spi_input_sync #(
    parameter bit CPOL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic sck_lead,
    output logic sck_trail,
    output logic ss_fall,
    output logic ss_rise,
    output logic ss_level,
    output logic mosi_level
);

    logic [1:0] sck_sync;
    logic [1:0] ss_sync;
    logic [1:0] mosi_sync;
    logic       sck_prev;
    logic       ss_prev;

    // Stages reset to the idle pin levels so releasing reset never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= {2{CPOL}};
            sck_prev  <= CPOL;
            ss_sync   <= 2'b11;
            ss_prev   <= 1'b1;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            sck_prev  <= sck_sync[1];
            ss_sync   <= {ss_sync[0], ss};
            ss_prev   <= ss_sync[1];
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign sck_lead   = (sck_sync[1] != sck_prev) && (sck_sync[1] != CPOL);
    assign sck_trail  = (sck_sync[1] != sck_prev) && (sck_sync[1] == CPOL);
    assign ss_fall    = ss_prev && !ss_sync[1];
    assign ss_rise    = !ss_prev && ss_sync[1];
    assign ss_level   = ss_sync[1];
    assign mosi_level = mosi_sync[1];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI register-file slave: R/W bit, address, data frames (CPHA=0) served from a resettable flop array.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit READ_POL  = 1'b1,
    parameter bit BURST_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 ss,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 wr_strobe,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] lrd_addr,
    output logic [DATA_BITS-1:0] lrd_data,
    output logic                 frame_err,
    output logic [1:0]           state_dbg
);

    localparam int DEPTH   = 1 << ADDR_BITS;
    localparam int MAX_LEN = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic sck_lead, sck_trail, ss_fall, ss_rise, ss_level, mosi_level;

    spi_input_sync #(.CPOL(CPOL)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .ss        (ss),
        .mosi      (mosi),
        .sck_lead  (sck_lead),
        .sck_trail (sck_trail),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .ss_level  (ss_level),
        .mosi_level(mosi_level)
    );

    spi_state_e           state;
    logic                 is_read;
    logic                 word_done;
    logic [CNT_W-1:0]     bit_cnt;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] regs [DEPTH];

    logic [ADDR_BITS-1:0] addr_next;
    logic [ADDR_BITS-1:0] addr_inc;
    logic [DATA_BITS-1:0] word_in;
    logic                 addr_last;
    logic                 data_last;
    logic                 lead_act;
    logic                 trail_act;
    logic                 data_lead;
    logic                 commit;

    // Edges only count while the slave is selected.
    assign lead_act  = sck_lead && !ss_level;
    assign trail_act = sck_trail && !ss_level;
    assign addr_next = {addr[ADDR_BITS-2:0], mosi_level};
    assign addr_inc  = addr + ADDR_BITS'(1);
    assign word_in   = {shreg[DATA_BITS-2:0], mosi_level};
    assign addr_last = (bit_cnt == CNT_W'(ADDR_BITS - 1));
    assign data_last = (bit_cnt == CNT_W'(DATA_BITS - 1));
    assign data_lead = (state == ST_DATA) && lead_act && !word_done;
    assign commit    = data_lead && !is_read && data_last;

    assign lrd_data  = regs[lrd_addr];
    assign state_dbg = state;

    // Old contents stay visible on lrd_data until this edge commits the new word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[addr] <= word_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            is_read   <= 1'b0;
            word_done <= 1'b0;
            bit_cnt   <= '0;
            addr      <= '0;
            shreg     <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= commit;
            frame_err <= 1'b0;
            if (commit) begin
                wr_addr <= addr;
                wr_data <= word_in;
            end

            if (state != ST_IDLE && ss_rise) begin
                // A non-zero bit count means the deselect cut a word short.
                state     <= ST_IDLE;
                miso_oe   <= 1'b0;
                bit_cnt   <= '0;
                word_done <= 1'b0;
                frame_err <= (state == ST_ADDR || state == ST_DATA) && (bit_cnt != '0);
            end else begin
                case (state)
                    ST_IDLE: begin
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                        if (ss_fall) begin
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (lead_act) begin
                            is_read <= (mosi_level == READ_POL);
                            bit_cnt <= '0;
                            state   <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (lead_act) begin
                            addr <= addr_next;
                            if (addr_last) begin
                                bit_cnt <= '0;
                                state   <= ST_DATA;
                                if (is_read) begin
                                    shreg <= regs[addr_next];
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (trail_act && is_read && !word_done) begin
                            miso    <= shreg[DATA_BITS-1];
                            shreg   <= {shreg[DATA_BITS-2:0], 1'b0};
                            miso_oe <= 1'b1;
                        end else if (data_lead) begin
                            if (!is_read) begin
                                shreg <= word_in;
                            end
                            if (data_last) begin
                                bit_cnt <= '0;
                                miso_oe <= 1'b0;
                                if (BURST_EN) begin
                                    addr <= addr_inc;
                                    if (is_read) begin
                                        shreg <= regs[addr_inc];
                                    end
                                end else begin
                                    word_done <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: a CPOL=0 and a CPOL=1 instance driven by the same frames (sck inverted for the second).
module tb_spi_reg_slave;
    import spi_reg_pkg::*;

    localparam int AB       = 7;
    localparam int DB       = 8;
    localparam int CLK_HALF = 5;
    // sck runs at clk/8
    localparam int SCK_HALF = 2 * SPI_MIN_OVERSAMPLE * CLK_HALF;

    logic          clk, reset, sck0, sck1, ss, mosi;
    logic [AB-1:0] lrd_addr;

    logic          miso0, miso_oe0, wr_strobe0, frame_err0;
    logic [AB-1:0] wr_addr0;
    logic [DB-1:0] wr_data0, lrd_data0;
    logic [1:0]    state_dbg0;
    logic          miso1, miso_oe1, wr_strobe1, frame_err1;
    logic [AB-1:0] wr_addr1;
    logic [DB-1:0] wr_data1, lrd_data1;
    logic [1:0]    state_dbg1;

    logic [20:0]   obs0, obs1;
    logic [31:0]   rx0, rx1, oe0, oe1;

    logic [AB+DB-1:0] exp_wr_q0[$];
    logic [AB+DB-1:0] exp_wr_q1[$];
    logic [DB-1:0]    exp_rd_q[$];
    logic [AB+DB-1:0] exp_w0, exp_w1;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt0 = 0, strobe_cnt1 = 0;
    int ferr_cnt0 = 0, ferr_cnt1 = 0;

    assign sck1 = ~sck0;
    assign obs0 = {miso0, miso_oe0, wr_strobe0, wr_addr0, wr_data0, frame_err0, state_dbg0};
    assign obs1 = {miso1, miso_oe1, wr_strobe1, wr_addr1, wr_data1, frame_err1, state_dbg1};

    spi_reg_slave #(.ADDR_BITS(AB), .DATA_BITS(DB), .CPOL(1'b0), .READ_POL(1'b1), .BURST_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .sck(sck0), .ss(ss), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0),
        .wr_data(wr_data0), .lrd_addr(lrd_addr), .lrd_data(lrd_data0),
        .frame_err(frame_err0), .state_dbg(state_dbg0)
    );

    spi_reg_slave #(.ADDR_BITS(AB), .DATA_BITS(DB), .CPOL(1'b1), .READ_POL(1'b1), .BURST_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .sck(sck1), .ss(ss), .mosi(mosi),
        .miso(miso1), .miso_oe(miso_oe1), .wr_strobe(wr_strobe1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .lrd_addr(lrd_addr), .lrd_data(lrd_data1),
        .frame_err(frame_err1), .state_dbg(state_dbg1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #CLK_HALF clk = ~clk;

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err0) ferr_cnt0++;
            if (wr_strobe0) begin
                strobe_cnt0++;
                n_checks++;
                if (exp_wr_q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_commit dut0: got %h:%h, expected no write", wr_addr0, wr_data0);
                end else begin
                    exp_w0 = exp_wr_q0.pop_front();
                    if ({wr_addr0, wr_data0} !== exp_w0) begin
                        n_fail++;
                        $display("FAIL wr_commit dut0: got %h:%h, expected %h:%h",
                                 wr_addr0, wr_data0, exp_w0[AB+DB-1:DB], exp_w0[DB-1:0]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err1) ferr_cnt1++;
            if (wr_strobe1) begin
                strobe_cnt1++;
                n_checks++;
                if (exp_wr_q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_commit dut1: got %h:%h, expected no write", wr_addr1, wr_data1);
                end else begin
                    exp_w1 = exp_wr_q1.pop_front();
                    if ({wr_addr1, wr_data1} !== exp_w1) begin
                        n_fail++;
                        $display("FAIL wr_commit dut1: got %h:%h, expected %h:%h",
                                 wr_addr1, wr_data1, exp_w1[AB+DB-1:DB], exp_w1[DB-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic spi_start();
        @(negedge clk);
        #2 ss = 1'b0;
        #SCK_HALF;
    endtask

    task automatic spi_bits(input logic [31:0] tx, input int n);
        rx0 = '0; rx1 = '0; oe0 = '0; oe1 = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            #SCK_HALF;
            sck0 = 1'b1;
            rx0 = {rx0[30:0], miso0};
            rx1 = {rx1[30:0], miso1};
            oe0 = {oe0[30:0], miso_oe0};
            oe1 = {oe1[30:0], miso_oe1};
            #SCK_HALF;
            sck0 = 1'b0;
        end
    endtask

    task automatic spi_end();
        #SCK_HALF;
        ss   = 1'b1;
        mosi = 1'b0;
        #(4 * SCK_HALF);
    endtask

    task automatic spi_write(input logic [AB-1:0] a, input logic [DB-1:0] d);
        exp_wr_q0.push_back({a, d});
        exp_wr_q1.push_back({a, d});
        spi_start();
        spi_bits({16'h0, 1'b0, a, d}, 16);
        spi_end();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs0 !== '0) begin n_fail++; $display("FAIL reset_outputs dut0: got %h, expected 0", obs0); end
        n_checks++;
        if (obs1 !== '0) begin n_fail++; $display("FAIL reset_outputs dut1: got %h, expected 0", obs1); end
        for (int k = 0; k < 4; k++) begin
            lrd_addr = AB'(k * 37 + 3);
            #1;
            n_checks++;
            if (lrd_data0 !== '0 || lrd_data1 !== '0) begin
                n_fail++;
                $display("FAIL reset_regs @%h: got %h/%h, expected 00", lrd_addr, lrd_data0, lrd_data1);
            end
        end
    endtask

    task automatic test_write();
        int s0 = strobe_cnt0, s1 = strobe_cnt1, f0 = ferr_cnt0, f1 = ferr_cnt1;
        spi_write(7'h12, 8'h34);
        n_checks++;
        if (strobe_cnt0 - s0 != 1 || strobe_cnt1 - s1 != 1) begin
            n_fail++; $display("FAIL write_strobes: got %0d/%0d, expected 1", strobe_cnt0 - s0, strobe_cnt1 - s1);
        end
        n_checks++;
        if (exp_wr_q0.size() != 0 || exp_wr_q1.size() != 0) begin
            n_fail++; $display("FAIL write_pending: got %0d/%0d left, expected 0", exp_wr_q0.size(), exp_wr_q1.size());
        end
        n_checks++;
        if (ferr_cnt0 != f0 || ferr_cnt1 != f1) begin
            n_fail++; $display("FAIL write_clean_end: got %0d/%0d frame errors, expected 0", ferr_cnt0 - f0, ferr_cnt1 - f1);
        end
        lrd_addr = 7'h12;
        #1;
        n_checks++;
        if (lrd_data0 !== 8'h34 || lrd_data1 !== 8'h34) begin
            n_fail++; $display("FAIL write_lrd: got %h/%h, expected 34", lrd_data0, lrd_data1);
        end
    endtask

    task automatic test_read();
        logic [DB-1:0] e;
        int s0 = strobe_cnt0;
        exp_rd_q.push_back(8'h34);
        spi_start();
        spi_bits({16'h0, 1'b1, 7'h12, 8'h00}, 16);
        spi_end();
        e = exp_rd_q.pop_front();
        n_checks++;
        if (rx0[7:0] !== e) begin n_fail++; $display("FAIL read_data dut0: got %h, expected %h", rx0[7:0], e); end
        n_checks++;
        if (rx1[7:0] !== e) begin n_fail++; $display("FAIL read_data dut1: got %h, expected %h", rx1[7:0], e); end
        n_checks++;
        if (oe0[15:0] !== 16'h00FF || oe1[15:0] !== 16'h00FF) begin
            n_fail++; $display("FAIL read_oe_window: got %h/%h, expected 00ff", oe0[15:0], oe1[15:0]);
        end
        n_checks++;
        if (miso_oe0 !== 1'b0 || miso_oe1 !== 1'b0 || strobe_cnt0 != s0) begin
            n_fail++; $display("FAIL read_after: oe %b/%b strobes %0d, expected oe 0 and 0 strobes",
                               miso_oe0, miso_oe1, strobe_cnt0 - s0);
        end
    endtask

    task automatic test_burst();
        int s0 = strobe_cnt0, s1 = strobe_cnt1;
        logic [AB-1:0] addrs [3];
        logic [DB-1:0] datas [3];
        addrs = '{7'h7F, 7'h00, 7'h01};
        datas = '{8'hAA, 8'hBB, 8'hCC};
        for (int k = 0; k < 3; k++) begin
            exp_wr_q0.push_back({addrs[k], datas[k]});
            exp_wr_q1.push_back({addrs[k], datas[k]});
        end
        spi_start();
        spi_bits({1'b0, 7'h7F, 8'hAA, 8'hBB, 8'hCC}, 32);
        spi_end();
        n_checks++;
        if (strobe_cnt0 - s0 != 3 || strobe_cnt1 - s1 != 3) begin
            n_fail++; $display("FAIL burst_strobes: got %0d/%0d, expected 3", strobe_cnt0 - s0, strobe_cnt1 - s1);
        end
        for (int k = 0; k < 3; k++) begin
            lrd_addr = addrs[k];
            #1;
            n_checks++;
            if (lrd_data0 !== datas[k] || lrd_data1 !== datas[k]) begin
                n_fail++; $display("FAIL burst_lrd @%h: got %h/%h, expected %h", addrs[k], lrd_data0, lrd_data1, datas[k]);
            end
        end
    endtask

    task automatic test_burst_read();
        logic [DB-1:0] e;
        exp_rd_q.push_back(8'hAA);
        exp_rd_q.push_back(8'hBB);
        exp_rd_q.push_back(8'hCC);
        spi_start();
        spi_bits({1'b1, 7'h7F, 24'h0}, 32);
        spi_end();
        for (int k = 2; k >= 0; k--) begin
            e = exp_rd_q.pop_front();
            n_checks++;
            if (rx0[8*k +: 8] !== e || rx1[8*k +: 8] !== e) begin
                n_fail++; $display("FAIL burst_read byte %0d: got %h/%h, expected %h", 2 - k, rx0[8*k +: 8], rx1[8*k +: 8], e);
            end
        end
        n_checks++;
        if (oe0 !== 32'h00FF_FFFF || oe1 !== 32'h00FF_FFFF) begin
            n_fail++; $display("FAIL burst_read_oe: got %h/%h, expected 00ffffff", oe0, oe1);
        end
    endtask

    task automatic test_abort();
        int s0, f0, f1;
        spi_write(7'h05, 8'h5A);
        s0 = strobe_cnt0; f0 = ferr_cnt0; f1 = ferr_cnt1;
        spi_start();
        spi_bits({20'h0, 1'b0, 7'h05, 4'hF}, 12);
        spi_end();
        n_checks++;
        if (ferr_cnt0 - f0 != 1 || ferr_cnt1 - f1 != 1) begin
            n_fail++; $display("FAIL abort_frame_err: got %0d/%0d cycles, expected 1", ferr_cnt0 - f0, ferr_cnt1 - f1);
        end
        n_checks++;
        if (strobe_cnt0 != s0) begin
            n_fail++; $display("FAIL abort_no_write: got %0d strobes, expected 0", strobe_cnt0 - s0);
        end
        lrd_addr = 7'h05;
        #1;
        n_checks++;
        if (lrd_data0 !== 8'h5A || lrd_data1 !== 8'h5A) begin
            n_fail++; $display("FAIL abort_reg_kept: got %h/%h, expected 5a", lrd_data0, lrd_data1);
        end
    endtask

    task automatic test_reset_mid();
        int s0 = strobe_cnt0, f0 = ferr_cnt0, f1 = ferr_cnt1;
        spi_start();
        spi_bits({20'h0, 1'b0, 7'h0A, 4'h3}, 12);
        #SCK_HALF;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs0 !== '0) begin n_fail++; $display("FAIL midreset_outputs dut0: got %h, expected 0", obs0); end
        n_checks++;
        if (obs1 !== '0) begin n_fail++; $display("FAIL midreset_outputs dut1: got %h, expected 0", obs1); end
        lrd_addr = 7'h12;
        #1;
        n_checks++;
        if (lrd_data0 !== '0 || lrd_data1 !== '0) begin
            n_fail++; $display("FAIL midreset_regs: got %h/%h, expected 00", lrd_data0, lrd_data1);
        end
        ss = 1'b1;
        mosi = 1'b0;
        #(4 * SCK_HALF);
        reset = 1'b0;
        #(4 * SCK_HALF);
        n_checks++;
        if (strobe_cnt0 != s0 || ferr_cnt0 != f0 || ferr_cnt1 != f1) begin
            n_fail++; $display("FAIL midreset_quiet: got %0d strobes %0d/%0d errors, expected none",
                               strobe_cnt0 - s0, ferr_cnt0 - f0, ferr_cnt1 - f1);
        end
        spi_write(7'h03, 8'h01);
        n_checks++;
        if (strobe_cnt0 - s0 != 1 || exp_wr_q0.size() != 0 || exp_wr_q1.size() != 0) begin
            n_fail++; $display("FAIL midreset_resume: got %0d strobes %0d pending, expected 1 and 0",
                               strobe_cnt0 - s0, exp_wr_q0.size() + exp_wr_q1.size());
        end
        lrd_addr = 7'h03;
        #1;
        n_checks++;
        if (lrd_data0 !== 8'h01 || lrd_data1 !== 8'h01) begin
            n_fail++; $display("FAIL midreset_commit: got %h/%h, expected 01", lrd_data0, lrd_data1);
        end
    endtask

    initial begin
        reset    = 1'b1;
        ss       = 1'b1;
        sck0     = 1'b0;
        mosi     = 1'b0;
        lrd_addr = '0;
        test_reset();
        test_write();
        test_read();
        test_burst();
        test_burst_read();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
